// File: rtl/c7bbiu_rd_arb_if.sv
// Read-arbiter bus bundle: icache and dcache requester sides plus the BIU read port.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface c7bbiu_rd_arb_if;
  // icache requester
  logic        icu_arb_req;
  logic [28:0] icu_arb_addr;
  logic        icu_arb_single;
  logic        arb_icu_ack;
  logic        arb_icu_data_valid;
  logic        arb_icu_data_last;
  logic        arb_icu_fault;
  // dcache requester
  logic        dcu_arb_req;
  logic [28:0] dcu_arb_addr;
  logic        dcu_arb_single;
  logic        arb_dcu_ack;
  logic        arb_dcu_data_valid;
  logic        arb_dcu_data_last;
  logic        arb_dcu_fault;
  // shared read data and BIU port
  logic [63:0] arb_data;
  logic        arb_biu_req;
  logic [28:0] arb_biu_addr;
  logic        arb_biu_single;
  logic        biu_arb_ack;
  logic        biu_arb_data_valid;
  logic        biu_arb_data_last;
  logic [63:0] biu_arb_data;
  logic        biu_arb_fault;
  logic        arb_proto_err;

  modport slave (
    input  icu_arb_req, icu_arb_addr, icu_arb_single,
    output arb_icu_ack, arb_icu_data_valid, arb_icu_data_last, arb_icu_fault,
    input  dcu_arb_req, dcu_arb_addr, dcu_arb_single,
    output arb_dcu_ack, arb_dcu_data_valid, arb_dcu_data_last, arb_dcu_fault,
    output arb_data, arb_biu_req, arb_biu_addr, arb_biu_single,
    input  biu_arb_ack, biu_arb_data_valid, biu_arb_data_last, biu_arb_data, biu_arb_fault,
    output arb_proto_err
  );

  modport master (
    output icu_arb_req, icu_arb_addr, icu_arb_single,
    input  arb_icu_ack, arb_icu_data_valid, arb_icu_data_last, arb_icu_fault,
    output dcu_arb_req, dcu_arb_addr, dcu_arb_single,
    input  arb_dcu_ack, arb_dcu_data_valid, arb_dcu_data_last, arb_dcu_fault,
    input  arb_data, arb_biu_req, arb_biu_addr, arb_biu_single,
    output biu_arb_ack, biu_arb_data_valid, biu_arb_data_last, biu_arb_data, biu_arb_fault,
    input  arb_proto_err
  );
endinterface

// File: rtl/c7bbiu_rd_arb.sv
// Two-requester read arbiter (icache line fill / dcache) in front of the BIU read port.
// Grant is held from request through the final beat; responses are steered to the owner
// only, and beat counts are checked against single/line to raise a sticky protocol error.
module c7bbiu_rd_arb #(
  parameter bit RR_EN    = 1'b1,
  parameter bit INIT_PRI = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  c7bbiu_rd_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        own_dcu, own_dcu_nxt;     // 0: icu owns the port, 1: dcu
  logic [28:0] addr_q, addr_nxt;
  logic        single_q, single_nxt;
  logic        pri_dcu, pri_dcu_nxt;     // 1: dcu wins the next tie
  logic [2:0]  beat_cnt, beat_cnt_nxt;   // valid beats seen in the current burst
  logic        proto_err, proto_err_nxt;

  logic        beat;
  logic        burst_end;
  logic        arb_en;
  logic        gnt_icu;
  logic        gnt_dcu;
  logic        exp_last;
  logic        ack_fwd;

  // State, owner, pointer, beat counter and sticky error registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      own_dcu   <= 1'b0;
      addr_q    <= '0;
      single_q  <= 1'b0;
      pri_dcu   <= INIT_PRI;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      own_dcu   <= own_dcu_nxt;
      addr_q    <= addr_nxt;
      single_q  <= single_nxt;
      pri_dcu   <= pri_dcu_nxt;
      beat_cnt  <= beat_cnt_nxt;
      proto_err <= proto_err_nxt;
    end
  end

  // Arbitration, next-state, beat checking and owner-steered outputs
  always_comb begin
    state_nxt     = state;
    own_dcu_nxt   = own_dcu;
    addr_nxt      = addr_q;
    single_nxt    = single_q;
    pri_dcu_nxt   = pri_dcu;
    beat_cnt_nxt  = beat_cnt;
    proto_err_nxt = proto_err;
    gnt_icu       = 1'b0;
    gnt_dcu       = 1'b0;

    beat      = (state == DATA) && bus.biu_arb_data_valid;
    // A fault terminates the burst and is treated as its last beat.
    burst_end = beat && (bus.biu_arb_data_last || bus.biu_arb_fault);
    arb_en    = (state == IDLE) || burst_end;
    ack_fwd   = (state == REQ) && bus.biu_arb_ack;
    exp_last  = single_q ? (beat_cnt == 3'd0) : (beat_cnt == 3'd3);

    if (arb_en) begin
      if (bus.icu_arb_req && bus.dcu_arb_req) begin
        if (RR_EN && pri_dcu) gnt_dcu = 1'b1;
        else                  gnt_icu = 1'b1;
      end else if (bus.icu_arb_req) begin
        gnt_icu = 1'b1;
      end else if (bus.dcu_arb_req) begin
        gnt_dcu = 1'b1;
      end
    end

    if (gnt_icu) begin
      own_dcu_nxt = 1'b0;
      addr_nxt    = bus.icu_arb_addr;
      single_nxt  = bus.icu_arb_single;
      pri_dcu_nxt = 1'b1;
    end else if (gnt_dcu) begin
      own_dcu_nxt = 1'b1;
      addr_nxt    = bus.dcu_arb_addr;
      single_nxt  = bus.dcu_arb_single;
      pri_dcu_nxt = 1'b0;
    end

    case (state)
      IDLE:    if (gnt_icu || gnt_dcu) state_nxt = REQ;
      REQ:     if (bus.biu_arb_ack) state_nxt = DATA;
      DATA:    if (burst_end) state_nxt = (gnt_icu || gnt_dcu) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase

    if (burst_end)  beat_cnt_nxt = '0;
    else if (beat)  beat_cnt_nxt = beat_cnt + 3'd1;

    // Early or late last on a non-faulting beat, or any stray handshake.
    if (beat && !bus.biu_arb_fault && (bus.biu_arb_data_last != exp_last))
      proto_err_nxt = 1'b1;
    if (bus.biu_arb_data_valid && (state != DATA))
      proto_err_nxt = 1'b1;
    if (bus.biu_arb_ack && (state != REQ))
      proto_err_nxt = 1'b1;

    bus.arb_biu_req    = (state == REQ);
    bus.arb_biu_addr   = addr_q;
    bus.arb_biu_single = single_q;
    bus.arb_data       = (state == DATA) ? bus.biu_arb_data : '0;
    bus.arb_proto_err  = proto_err;

    bus.arb_icu_ack        = ack_fwd && !own_dcu;
    bus.arb_icu_data_valid = beat && !own_dcu;
    bus.arb_icu_data_last  = burst_end && !own_dcu;
    bus.arb_icu_fault      = beat && bus.biu_arb_fault && !own_dcu;

    bus.arb_dcu_ack        = ack_fwd && own_dcu;
    bus.arb_dcu_data_valid = beat && own_dcu;
    bus.arb_dcu_data_last  = burst_end && own_dcu;
    bus.arb_dcu_fault      = beat && bus.biu_arb_fault && own_dcu;
  end

endmodule

// File: tb/tb_c7bbiu_rd_arb.sv
// Directed bench for c7bbiu_rd_arb (RR_EN=1, INIT_PRI=0): line fill, round-robin with
// back-to-back grants, single beat, fault termination, early last, mid-burst reset.
module tb_c7bbiu_rd_arb;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  c7bbiu_rd_arb_if bus();

  c7bbiu_rd_arb #(.RR_EN(1'b1), .INIT_PRI(1'b0)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic biu_idle();
    bus.biu_arb_ack        = 1'b0;
    bus.biu_arb_data_valid = 1'b0;
    bus.biu_arb_data_last  = 1'b0;
    bus.biu_arb_fault      = 1'b0;
    bus.biu_arb_data       = 64'h0;
  endtask

  task automatic biu_beat(input logic [63:0] d, input logic last, input logic fault);
    bus.biu_arb_ack        = 1'b0;
    bus.biu_arb_data_valid = 1'b1;
    bus.biu_arb_data_last  = last;
    bus.biu_arb_fault      = fault;
    bus.biu_arb_data       = d;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    biu_idle();
    cyc();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    bus.icu_arb_req = 1'b1; bus.icu_arb_addr = 29'h1; bus.icu_arb_single = 1'b0;
    bus.dcu_arb_req = 1'b0; bus.dcu_arb_addr = 29'h0; bus.dcu_arb_single = 1'b0;
    biu_idle();
    bus.biu_arb_data = 64'hDEAD_BEEF_0000_0001;
    resetn = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.arb_biu_req !== 1'b0) begin failures++; $display("FAIL rst_biu_req got=%b exp=0", bus.arb_biu_req); end
    checks++; if ({bus.arb_biu_addr, bus.arb_biu_single} !== 30'h0) begin failures++; $display("FAIL rst_biu_addr got=%h exp=0", bus.arb_biu_addr); end
    checks++; if ({bus.arb_icu_ack, bus.arb_icu_data_valid, bus.arb_icu_data_last, bus.arb_icu_fault} !== 4'h0) begin failures++; $display("FAIL rst_icu_out got=%b exp=0000", {bus.arb_icu_ack, bus.arb_icu_data_valid, bus.arb_icu_data_last, bus.arb_icu_fault}); end
    checks++; if ({bus.arb_dcu_ack, bus.arb_dcu_data_valid, bus.arb_dcu_data_last, bus.arb_dcu_fault} !== 4'h0) begin failures++; $display("FAIL rst_dcu_out got=%b exp=0000", {bus.arb_dcu_ack, bus.arb_dcu_data_valid, bus.arb_dcu_data_last, bus.arb_dcu_fault}); end
    checks++; if (bus.arb_data !== 64'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", bus.arb_data); end
    checks++; if (bus.arb_proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto_err got=%b exp=0", bus.arb_proto_err); end
    bus.icu_arb_req = 1'b0;
    biu_idle();
    resetn = 1'b1;
    cyc();
  endtask

  // 1: icu line fill alone
  task automatic test_icu_line();
    bus.icu_arb_req = 1'b1; bus.icu_arb_addr = 29'h20; bus.icu_arb_single = 1'b0;
    #1;
    checks++; if (bus.arb_biu_req !== 1'b0) begin failures++; $display("FAIL t1_req_lat0 got=%b exp=0", bus.arb_biu_req); end
    cyc();
    checks++; if (bus.arb_biu_req !== 1'b1) begin failures++; $display("FAIL t1_req got=%b exp=1", bus.arb_biu_req); end
    checks++; if ({bus.arb_biu_addr, bus.arb_biu_single} !== {29'h20, 1'b0}) begin failures++; $display("FAIL t1_addr got=%h/%b exp=20/0", bus.arb_biu_addr, bus.arb_biu_single); end
    bus.biu_arb_ack = 1'b1;
    #1;
    checks++; if ({bus.arb_icu_ack, bus.arb_dcu_ack} !== 2'b10) begin failures++; $display("FAIL t1_ack got=%b exp=10", {bus.arb_icu_ack, bus.arb_dcu_ack}); end
    cyc();
    bus.icu_arb_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      biu_beat(64'hA0 + 64'(i), (i == 3), 1'b0);
      #1;
      checks++; if ({bus.arb_icu_data_valid, bus.arb_icu_data_last} !== {1'b1, (i == 3)}) begin failures++; $display("FAIL t1_beat%0d_vl got=%b exp=1%b", i, {bus.arb_icu_data_valid, bus.arb_icu_data_last}, (i == 3)); end
      checks++; if (bus.arb_data !== 64'hA0 + 64'(i)) begin failures++; $display("FAIL t1_beat%0d_data got=%h exp=%h", i, bus.arb_data, 64'hA0 + 64'(i)); end
      checks++; if ({bus.arb_dcu_data_valid, bus.arb_dcu_data_last, bus.arb_dcu_fault, bus.arb_dcu_ack} !== 4'h0) begin failures++; $display("FAIL t1_beat%0d_dcu got=%b exp=0000", i, {bus.arb_dcu_data_valid, bus.arb_dcu_data_last, bus.arb_dcu_fault, bus.arb_dcu_ack}); end
    end
    cyc();
    biu_idle();
    #1;
    checks++; if ({bus.arb_biu_req, bus.arb_icu_data_valid, bus.arb_proto_err} !== 3'b000) begin failures++; $display("FAIL t1_end got=%b exp=000", {bus.arb_biu_req, bus.arb_icu_data_valid, bus.arb_proto_err}); end
    cyc();
  endtask

  // 2: simultaneous requests, round-robin, back-to-back grants, re-request in own last cycle
  task automatic test_back_to_back();
    do_reset();
    bus.icu_arb_req = 1'b1; bus.icu_arb_addr = 29'h100;  bus.icu_arb_single = 1'b0;
    bus.dcu_arb_req = 1'b1; bus.dcu_arb_addr = 29'h1234; bus.dcu_arb_single = 1'b1;
    cyc();
    checks++; if ({bus.arb_biu_req, bus.arb_biu_addr} !== {1'b1, 29'h100}) begin failures++; $display("FAIL t2_icu_first got=%b/%h exp=1/100", bus.arb_biu_req, bus.arb_biu_addr); end
    bus.biu_arb_ack = 1'b1;
    #1;
    checks++; if ({bus.arb_icu_ack, bus.arb_dcu_ack} !== 2'b10) begin failures++; $display("FAIL t2_icu_ack got=%b exp=10", {bus.arb_icu_ack, bus.arb_dcu_ack}); end
    cyc();
    bus.icu_arb_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      biu_beat(64'hC0 + 64'(i), (i == 3), 1'b0);
    end
    // icu re-requests in its own last cycle; dcu must still win by round-robin
    bus.icu_arb_req = 1'b1; bus.icu_arb_addr = 29'h0ABC; bus.icu_arb_single = 1'b1;
    #1;
    checks++; if ({bus.arb_icu_data_last, bus.arb_biu_req} !== 2'b10) begin failures++; $display("FAIL t2_icu_last got=%b exp=10", {bus.arb_icu_data_last, bus.arb_biu_req}); end
    cyc();
    biu_idle();
    #1;
    checks++; if ({bus.arb_biu_req, bus.arb_biu_addr, bus.arb_biu_single} !== {1'b1, 29'h1234, 1'b1}) begin failures++; $display("FAIL t2_dcu_nogap got=%b/%h/%b exp=1/1234/1", bus.arb_biu_req, bus.arb_biu_addr, bus.arb_biu_single); end
    bus.biu_arb_ack = 1'b1;
    #1;
    checks++; if ({bus.arb_icu_ack, bus.arb_dcu_ack} !== 2'b01) begin failures++; $display("FAIL t2_dcu_ack got=%b exp=01", {bus.arb_icu_ack, bus.arb_dcu_ack}); end
    cyc();
    bus.dcu_arb_req = 1'b0;
    biu_beat(64'hBB, 1'b1, 1'b0);
    #1;
    checks++; if ({bus.arb_dcu_data_valid, bus.arb_dcu_data_last, bus.arb_icu_data_valid} !== 3'b110) begin failures++; $display("FAIL t2_dcu_beat got=%b exp=110", {bus.arb_dcu_data_valid, bus.arb_dcu_data_last, bus.arb_icu_data_valid}); end
    cyc();
    biu_idle();
    #1;
    checks++; if ({bus.arb_biu_req, bus.arb_biu_addr} !== {1'b1, 29'h0ABC}) begin failures++; $display("FAIL t2_icu_again got=%b/%h exp=1/0abc", bus.arb_biu_req, bus.arb_biu_addr); end
    bus.biu_arb_ack = 1'b1;
    cyc();
    bus.icu_arb_req = 1'b0;
    biu_beat(64'hCC, 1'b1, 1'b0);
    cyc();
    biu_idle();
    #1;
    checks++; if ({bus.arb_biu_req, bus.arb_proto_err} !== 2'b00) begin failures++; $display("FAIL t2_end got=%b exp=00", {bus.arb_biu_req, bus.arb_proto_err}); end
    cyc();
  endtask

  // 3: dcu single beat at top address
  task automatic test_dcu_single();
    bus.dcu_arb_req = 1'b1; bus.dcu_arb_addr = 29'h1FFF_FFFF; bus.dcu_arb_single = 1'b1;
    cyc();
    checks++; if ({bus.arb_biu_req, bus.arb_biu_addr, bus.arb_biu_single} !== {1'b1, 29'h1FFF_FFFF, 1'b1}) begin failures++; $display("FAIL t3_req got=%b/%h/%b exp=1/1fffffff/1", bus.arb_biu_req, bus.arb_biu_addr, bus.arb_biu_single); end
    bus.biu_arb_ack = 1'b1;
    cyc();
    bus.dcu_arb_req = 1'b0;
    biu_beat(64'h1122_3344_5566_7788, 1'b1, 1'b0);
    #1;
    checks++; if ({bus.arb_dcu_data_valid, bus.arb_dcu_data_last, bus.arb_data} !== {2'b11, 64'h1122_3344_5566_7788}) begin failures++; $display("FAIL t3_beat got=%b%b/%h exp=11/1122334455667788", bus.arb_dcu_data_valid, bus.arb_dcu_data_last, bus.arb_data); end
    cyc();
    biu_idle();
    #1;
    checks++; if ({bus.arb_biu_req, bus.arb_dcu_data_valid, bus.arb_proto_err} !== 3'b000) begin failures++; $display("FAIL t3_idle got=%b exp=000", {bus.arb_biu_req, bus.arb_dcu_data_valid, bus.arb_proto_err}); end
    cyc();
  endtask

  // 4: fault on beat 2 of a line ends the burst
  task automatic test_fault();
    bus.icu_arb_req = 1'b1; bus.icu_arb_addr = 29'h40; bus.icu_arb_single = 1'b0;
    cyc();
    bus.biu_arb_ack = 1'b1;
    cyc();
    bus.icu_arb_req = 1'b0;
    biu_beat(64'hF0, 1'b0, 1'b0);
    cyc();
    biu_beat(64'hF1, 1'b0, 1'b1);
    #1;
    checks++; if ({bus.arb_icu_data_valid, bus.arb_icu_fault, bus.arb_icu_data_last, bus.arb_dcu_fault} !== 4'b1110) begin failures++; $display("FAIL t4_fault got=%b exp=1110", {bus.arb_icu_data_valid, bus.arb_icu_fault, bus.arb_icu_data_last, bus.arb_dcu_fault}); end
    cyc();
    biu_idle();
    bus.dcu_arb_req = 1'b1; bus.dcu_arb_addr = 29'h77; bus.dcu_arb_single = 1'b1;
    #1;
    checks++; if ({bus.arb_biu_req, bus.arb_proto_err} !== 2'b00) begin failures++; $display("FAIL t4_release got=%b exp=00", {bus.arb_biu_req, bus.arb_proto_err}); end
    cyc();
    checks++; if ({bus.arb_biu_req, bus.arb_biu_addr} !== {1'b1, 29'h77}) begin failures++; $display("FAIL t4_next_grant got=%b/%h exp=1/77", bus.arb_biu_req, bus.arb_biu_addr); end
    bus.biu_arb_ack = 1'b1;
    cyc();
    bus.dcu_arb_req = 1'b0;
    biu_beat(64'h77, 1'b1, 1'b0);
    cyc();
    biu_idle();
    cyc();
  endtask

  // 5: last on beat 3 of a line sets a sticky error cleared only by reset
  task automatic test_early_last();
    bus.icu_arb_req = 1'b1; bus.icu_arb_addr = 29'h60; bus.icu_arb_single = 1'b0;
    cyc();
    bus.biu_arb_ack = 1'b1;
    cyc();
    bus.icu_arb_req = 1'b0;
    biu_beat(64'hE0, 1'b0, 1'b0);
    cyc();
    biu_beat(64'hE1, 1'b0, 1'b0);
    cyc();
    biu_beat(64'hE2, 1'b1, 1'b0);
    #1;
    checks++; if (bus.arb_proto_err !== 1'b0) begin failures++; $display("FAIL t5_err_before got=%b exp=0", bus.arb_proto_err); end
    cyc();
    biu_idle();
    #1;
    checks++; if ({bus.arb_proto_err, bus.arb_biu_req} !== 2'b10) begin failures++; $display("FAIL t5_err_set got=%b exp=10", {bus.arb_proto_err, bus.arb_biu_req}); end
    bus.dcu_arb_req = 1'b1; bus.dcu_arb_addr = 29'h99; bus.dcu_arb_single = 1'b1;
    cyc();
    bus.biu_arb_ack = 1'b1;
    cyc();
    bus.dcu_arb_req = 1'b0;
    biu_beat(64'h99, 1'b1, 1'b0);
    cyc();
    biu_idle();
    cyc();
    checks++; if (bus.arb_proto_err !== 1'b1) begin failures++; $display("FAIL t5_err_sticky got=%b exp=1", bus.arb_proto_err); end
    do_reset();
    #1;
    checks++; if (bus.arb_proto_err !== 1'b0) begin failures++; $display("FAIL t5_err_cleared got=%b exp=0", bus.arb_proto_err); end
    cyc();
  endtask

  // 6: reset in DATA after beat 2, pending dcu request re-arbitrated afterwards
  task automatic test_reset_mid();
    bus.icu_arb_req = 1'b1; bus.icu_arb_addr = 29'h80;  bus.icu_arb_single = 1'b0;
    bus.dcu_arb_req = 1'b1; bus.dcu_arb_addr = 29'h555; bus.dcu_arb_single = 1'b1;
    cyc();
    checks++; if (bus.arb_biu_addr !== 29'h80) begin failures++; $display("FAIL t6_icu_first got=%h exp=80", bus.arb_biu_addr); end
    bus.biu_arb_ack = 1'b1;
    cyc();
    bus.icu_arb_req = 1'b0;
    biu_beat(64'hD0, 1'b0, 1'b0);
    cyc();
    biu_beat(64'hD1, 1'b0, 1'b0);
    cyc();
    biu_idle();
    bus.biu_arb_data = 64'h5A5A_5A5A_5A5A_5A5A;
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    #1;
    checks++; if ({bus.arb_biu_req, bus.arb_biu_addr, bus.arb_biu_single} !== 31'h0) begin failures++; $display("FAIL t6_rst_biu got=%b/%h/%b exp=0/0/0", bus.arb_biu_req, bus.arb_biu_addr, bus.arb_biu_single); end
    checks++; if ({bus.arb_icu_ack, bus.arb_icu_data_valid, bus.arb_icu_data_last, bus.arb_icu_fault, bus.arb_dcu_ack, bus.arb_dcu_data_valid, bus.arb_dcu_data_last, bus.arb_dcu_fault, bus.arb_proto_err} !== 9'h0) begin failures++; $display("FAIL t6_rst_out got=%b exp=0", {bus.arb_icu_ack, bus.arb_icu_data_valid, bus.arb_icu_data_last, bus.arb_icu_fault, bus.arb_dcu_ack, bus.arb_dcu_data_valid, bus.arb_dcu_data_last, bus.arb_dcu_fault, bus.arb_proto_err}); end
    checks++; if (bus.arb_data !== 64'h0) begin failures++; $display("FAIL t6_rst_data got=%h exp=0", bus.arb_data); end
    cyc();
    checks++; if ({bus.arb_biu_req, bus.arb_biu_addr, bus.arb_biu_single} !== {1'b1, 29'h555, 1'b1}) begin failures++; $display("FAIL t6_rearb got=%b/%h/%b exp=1/555/1", bus.arb_biu_req, bus.arb_biu_addr, bus.arb_biu_single); end
    bus.biu_arb_ack = 1'b1;
    #1;
    checks++; if ({bus.arb_icu_ack, bus.arb_dcu_ack} !== 2'b01) begin failures++; $display("FAIL t6_dcu_ack got=%b exp=01", {bus.arb_icu_ack, bus.arb_dcu_ack}); end
    cyc();
    bus.dcu_arb_req = 1'b0;
    biu_beat(64'h55, 1'b1, 1'b0);
    #1;
    checks++; if ({bus.arb_dcu_data_valid, bus.arb_dcu_data_last} !== 2'b11) begin failures++; $display("FAIL t6_dcu_beat got=%b exp=11", {bus.arb_dcu_data_valid, bus.arb_dcu_data_last}); end
    cyc();
    biu_idle();
    #1;
    checks++; if ({bus.arb_biu_req, bus.arb_proto_err} !== 2'b00) begin failures++; $display("FAIL t6_end got=%b exp=00", {bus.arb_biu_req, bus.arb_proto_err}); end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_icu_line();
    test_back_to_back();
    test_dcu_single();
    test_fault();
    test_early_last();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
